// File: rtl/spw_ctrl_out.sv
// spw_ctrl_out: Avalon-MM write port for the SpaceWire CODEC link-control bits.
//
// A 32-bit register window with four addresses:
//   0 DATA  - write replaces the control bits
//   1 SET   - write ORs into the control bits
//   2 CLR   - write clears the selected control bits
//   3 CMD   - bit0 requests a timed link-reset pulse, bit1 clears the sticky overrun flag
// A link-reset pulse lasts PULSE_CYCLES clocks. It is followed by GUARD_CYCLES clocks
// during which new requests are refused.
//
// Ports:
//   clk, reset_n          clock and synchronous active-low reset
//   address, chipselect,
//   write_n, writedata    Avalon-MM slave write interface
//   readdata              registered read data (1-cycle latency, no side effects)
//   out_port              control bits to CODEC; bit0 (link_start) is masked while link_rst is high
//   link_rst              link-reset command pulse
//   busy                  high while a pulse or guard interval is in progress
module spw_ctrl_out #(
    parameter int unsigned      WIDTH        = 3,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter int unsigned      PULSE_CYCLES = 8,
    parameter int unsigned      GUARD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             link_rst,
    output logic             busy
);

    localparam int unsigned MaxCycles = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES
                                                                      : GUARD_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
    localparam int unsigned PulseLoad = (PULSE_CYCLES == 0) ? 0 : PULSE_CYCLES - 1;
    localparam int unsigned GuardLoad = (GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1;

    typedef enum logic [1:0] {StIdle, StPulse, StGuard} state_e;

    state_e            state;
    logic [CntW-1:0]   counter;
    logic [WIDTH-1:0]  ctrl;
    logic              overrun;
    logic              wr;
    logic              cmd_wr;
    logic [WIDTH-1:0]  wd;
    logic [31:0]       rd_next;

    assign wr     = chipselect & ~write_n;
    assign cmd_wr = wr && (address == 2'd3);
    assign wd     = writedata[WIDTH-1:0];
    assign busy   = (state != StIdle);

    // The stored link_start bit is kept; only the driven copy is suppressed during the pulse.
    always_comb begin
        out_port = ctrl;
        if (link_rst) out_port[0] = 1'b0;
    end

    always_comb begin
        if (address == 2'd3) rd_next = {30'b0, overrun, busy};
        else                 rd_next = 32'(out_port);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl     <= RESET_VAL;
            readdata <= '0;
            link_rst <= 1'b0;
            state    <= StIdle;
            counter  <= '0;
            overrun  <= 1'b0;
        end else begin
            readdata <= rd_next;

            if (wr) begin
                case (address)
                    2'd0:    ctrl <= wd;
                    2'd1:    ctrl <= ctrl | wd;
                    2'd2:    ctrl <= ctrl & ~wd;
                    default: ;
                endcase
            end

            // Clear has priority over a simultaneously dropped request.
            if (cmd_wr && writedata[1])                overrun <= 1'b0;
            else if (cmd_wr && writedata[0] && busy)   overrun <= 1'b1;

            case (state)
                StIdle: begin
                    if (cmd_wr && writedata[0]) begin
                        state    <= StPulse;
                        counter  <= CntW'(PulseLoad);
                        link_rst <= 1'b1;
                    end
                end
                StPulse: begin
                    if (counter == '0) begin
                        link_rst <= 1'b0;
                        if (GUARD_CYCLES == 0) begin
                            state <= StIdle;
                        end else begin
                            state   <= StGuard;
                            counter <= CntW'(GuardLoad);
                        end
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                StGuard: begin
                    if (counter == '0) state <= StIdle;
                    else               counter <= counter - 1'b1;
                end
                default: begin
                    state    <= StIdle;
                    link_rst <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spw_ctrl_out.sv
// Testbench for spw_ctrl_out: table vectors, hand sequences and a randomized run against
// a cycle-count reference model (remaining busy cycles instead of FSM states).
module tb_spw_ctrl_out;

    localparam int unsigned P  = 8;
    localparam int unsigned G  = 4;
    localparam logic [2:0]  RV = 3'b100;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [2:0]  out_port;
    logic        link_rst;
    logic        busy;

    // Second instance: 1-cycle pulse, no guard.
    logic [1:0]  address1;
    logic        chipselect1;
    logic        write_n1;
    logic [31:0] writedata1;
    logic [31:0] readdata1;
    logic [2:0]  out_port1;
    logic        link_rst1;
    logic        busy1;

    spw_ctrl_out #(
        .WIDTH(3), .RESET_VAL(RV), .PULSE_CYCLES(P), .GUARD_CYCLES(G)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .link_rst(link_rst), .busy(busy)
    );

    spw_ctrl_out #(
        .WIDTH(3), .RESET_VAL(3'b000), .PULSE_CYCLES(1), .GUARD_CYCLES(0)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address1), .chipselect(chipselect1),
        .write_n(write_n1), .writedata(writedata1), .readdata(readdata1),
        .out_port(out_port1), .link_rst(link_rst1), .busy(busy1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: m_rem counts the cycles of busy still to come after the current edge.
    logic [2:0]  m_reg;
    logic        m_ovr;
    int          m_rem;
    logic [31:0] m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_out();
        return (m_rem > int'(G)) ? (m_reg & 3'b110) : m_reg;
    endfunction

    task automatic model_step();
        logic       accept;
        logic [2:0] wd;
        wd     = writedata[2:0];
        accept = 1'b0;
        if (!reset_n) begin
            m_reg = RV;
            m_ovr = 1'b0;
            m_rem = 0;
            m_rd  = '0;
        end else begin
            m_rd = (address == 2'd3) ? {30'b0, m_ovr, (m_rem > 0)} : {29'b0, m_out()};
            if (chipselect && !write_n) begin
                case (address)
                    2'd0: m_reg = wd;
                    2'd1: m_reg = m_reg | wd;
                    2'd2: m_reg = m_reg & ~wd;
                    default: begin
                        if (writedata[1])                    m_ovr = 1'b0;
                        else if (writedata[0] && m_rem > 0)  m_ovr = 1'b1;
                        accept = writedata[0] && (m_rem == 0);
                    end
                endcase
            end
            if (accept)         m_rem = int'(P + G);
            else if (m_rem > 0) m_rem = m_rem - 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_out_port", 32'(out_port), 32'(m_out()));
        check("model_link_rst", 32'(link_rst), 32'(m_rem > int'(G)));
        check("model_busy", 32'(busy), 32'(m_rem > 0));
        check("model_readdata", readdata, m_rd);
    endtask

    task automatic bus(input logic wr, input logic [1:0] a, input logic [31:0] d);
        chipselect = wr;
        write_n    = ~wr;
        address    = a;
        writedata  = d;
    endtask

    typedef struct {
        logic        rst_n;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [2:0]  e_out;
        logic        e_lr;
        logic        e_busy;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        vecs[0] = '{1'b0, 1'b0, 2'd0, 32'h0, RV,     1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 2'd0, 32'h0, RV,     1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 2'd0, 32'hffff_fff5, 3'b101, 1'b0, 1'b0, 32'h4};
        vecs[3] = '{1'b1, 1'b1, 2'd1, 32'h2, 3'b111, 1'b0, 1'b0, 32'h5};
        vecs[4] = '{1'b1, 1'b1, 2'd2, 32'h1, 3'b110, 1'b0, 1'b0, 32'h7};
        vecs[5] = '{1'b1, 1'b0, 2'd0, 32'h0, 3'b110, 1'b0, 1'b0, 32'h6};
        vecs[6] = '{1'b1, 1'b0, 2'd3, 32'h0, 3'b110, 1'b0, 1'b0, 32'h0};

        reset_n = 1'b0;
        bus(1'b0, 2'd0, 32'h0);
        chipselect1 = 1'b0; write_n1 = 1'b1; address1 = 2'd0; writedata1 = 32'h0;

        // Reset and register aliases.
        for (int i = 0; i < 7; i++) begin
            reset_n = vecs[i].rst_n;
            bus(vecs[i].wr, vecs[i].addr, vecs[i].wd);
            tick();
            check("vec_out_port", 32'(out_port), 32'(vecs[i].e_out));
            check("vec_link_rst", 32'(link_rst), 32'(vecs[i].e_lr));
            check("vec_busy", 32'(busy), 32'(vecs[i].e_busy));
            check("vec_readdata", readdata, vecs[i].e_rd);
        end

        // Pulse timing and link_start masking.
        bus(1'b1, 2'd0, 32'h7);
        tick();
        bus(1'b1, 2'd3, 32'h1);
        tick();
        bus(1'b0, 2'd0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            check("pulse_link_rst", 32'(link_rst), 32'(i < 8));
            check("pulse_busy", 32'(busy), 32'(i < 12));
            check("pulse_mask", 32'(out_port), (i < 8) ? 32'h6 : 32'h7);
            tick();
        end

        // Request during guard is dropped; clear of overrun.
        bus(1'b1, 2'd3, 32'h1);
        tick();
        bus(1'b0, 2'd3, 32'h0);
        for (int i = 0; i < 8; i++) tick();
        check("guard_no_pulse_yet", 32'(link_rst), 32'h0);
        bus(1'b1, 2'd3, 32'h1);
        tick();
        bus(1'b0, 2'd3, 32'h0);
        tick();
        check("overrun_read", readdata, 32'h3);
        check("guard_no_new_pulse", 32'(link_rst), 32'h0);
        bus(1'b1, 2'd3, 32'h2);
        tick();
        bus(1'b0, 2'd3, 32'h0);
        tick();
        check("cleared_busy_read", readdata, 32'h1);
        tick();
        check("cleared_idle_read", readdata, 32'h0);

        // Reset mid-pulse, then a fresh full pulse.
        bus(1'b1, 2'd3, 32'h1);
        tick();
        bus(1'b0, 2'd0, 32'h0);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        check("rst_abort_link_rst", 32'(link_rst), 32'h0);
        check("rst_abort_busy", 32'(busy), 32'h0);
        check("rst_abort_out_port", 32'(out_port), 32'(RV));
        reset_n = 1'b1;
        bus(1'b1, 2'd3, 32'h1);
        tick();
        bus(1'b0, 2'd0, 32'h0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (link_rst) n++;
            tick();
        end
        check("pulse_len_after_rst", n, 8);

        // One-cycle pulse, no guard: back-to-back requests.
        chipselect1 = 1'b1; write_n1 = 1'b0; address1 = 2'd3; writedata1 = 32'h1;
        tick();
        check("p1_link_rst_on", 32'(link_rst1), 32'h1);
        check("p1_busy_on", 32'(busy1), 32'h1);
        tick();
        check("p1_link_rst_off", 32'(link_rst1), 32'h0);
        check("p1_busy_off", 32'(busy1), 32'h0);
        chipselect1 = 1'b0; write_n1 = 1'b1;
        tick();
        check("p1_overrun_read", readdata1, 32'h2);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 79) != 0);
            bus($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
